ntru_axis_mult: RTL and testbench
=================================

NTRU_AXIS_MULT -- requirements
Module: ntru_axis_mult

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32: stream data width.
REQ-002 SHALL have parameter N, default 11: polynomial degree (coefficient count).
REQ-003 SHALL have parameter Q_BITS, default 11: coefficient width; the modulus is q = 2^Q_BITS.
REQ-004 SHALL have parameter M, default 1: parallel arithmetic lanes, 1 <= M <= N.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port din_tdata, input, D_WIDTH: input beat carrying h, r, m and mode.
REQ-008 SHALL have ports din_tvalid and din_tlast, input, 1: AXI4-Stream slave valid and last.
REQ-009 SHALL have port din_tready, output, 1: slave ready.
REQ-010 SHALL have port dout_tdata, output, D_WIDTH: result coefficient.
REQ-011 SHALL have ports dout_tvalid and dout_tlast, output, 1: master valid and last.
REQ-012 SHALL have port dout_tready, input, 1: master ready.
REQ-013 SHALL have port busy, output, 1: high in COMPUTE and OUT.
REQ-014 SHALL have port err_len, output, 1: sticky frame-length error flag.

Function
REQ-015 SHALL carry one coefficient per input beat, beat i = index i: [Q_BITS-1:0] h[i]; [Q_BITS+1:Q_BITS] r[i]; [Q_BITS+3:Q_BITS+2] m[i]; bit D_WIDTH-1 of beat 0 = mode; all other bits ignored; elaboration SHALL fail if Q_BITS+4 > D_WIDTH-1.
REQ-016 SHALL decode the ternary fields as 00=0, 01=+1, 11=-1 (q-1); 10 SHALL decode as 0.
REQ-017 SHALL compute e[k] = init[k] + sum over i of h[i]*r[(k-i) mod N], mod 2^Q_BITS (natural Q_BITS wrap), where init = m (decoded) if mode=1, else 0.
REQ-018 SHALL use FSM states LOAD, FLUSH, COMPUTE, OUT.
REQ-019 LOAD: din_tready=1; SHALL count accepted beats 0..N-1 and store h, r and init.
REQ-020 LOAD, tlast on beat j < N-1: SHALL discard the frame, set err_len, and remain in LOAD with count 0.
REQ-021 LOAD, beat N-1 with tlast: SHALL go to COMPUTE.
REQ-022 LOAD, beat N-1 without tlast: SHALL set err_len and go to FLUSH.
REQ-023 FLUSH: din_tready=1; SHALL discard beats until the tlast handshake, then go to COMPUTE using the stored N coefficients.
REQ-024 COMPUTE: SHALL run exactly N*ceil(N/M) cycles; each cycle, for the current j, SHALL add or subtract up to M h values into e[(i+j) mod N]; lanes with i >= N SHALL be masked; r[j]=0 SHALL still consume its cycles (constant time).
REQ-025 SHALL assert dout_tvalid exactly N*ceil(N/M)+2 cycles after the final input handshake.
REQ-026 OUT: din_tready=0; SHALL emit e[0..N-1] in [Q_BITS-1:0] with upper bits 0, dout_tlast only on e[N-1].
REQ-027 OUT: while dout_tvalid=1 and dout_tready=0, dout_tdata, dout_tvalid and dout_tlast SHALL hold stable.
REQ-028 OUT: after the e[N-1] handshake, dout_tvalid SHALL drop the next cycle and the FSM SHALL enter LOAD.
REQ-029 SHALL hold din_tready=0 throughout COMPUTE and OUT.
REQ-030 SHALL clear err_len on the first accepted beat of the next frame.

Reset
REQ-031 Reset SHALL force LOAD, all counters 0, and din_tready, dout_tvalid, dout_tlast, dout_tdata, busy and err_len to 0, regardless of state (including mid-COMPUTE or mid-OUT).
REQ-032 din_tready SHALL be registered and rise on the first clk edge after reset deasserts.
REQ-033 h, r and e storage SHALL NOT be reset; e SHALL be re-initialised per frame.

Structure
REQ-034 Package ntru_axis_pkg SHALL hold the clog2 function, the ternary encoding constants, and the FSM state enumeration.
REQ-035 SHALL instantiate sub-module ntru_au_lane M times: one combinational add/sub/pass of Q_BITS operands selected by r.
REQ-036 h, r and e SHALL be register arrays indexed with clog2(N-1)-bit addresses.

Verification (N=11, Q_BITS=11, run at M=1 and M=4)
REQ-037 Rotation test: h=1..11, r[1]=+1, others 0, mode=0 -> e = 11,1,2,...,10; dout_tlast only with 10.
REQ-038 Negation test: h[0]=5, r[0]=-1, others 0 -> e[0]=2043, e[1..10]=0.
REQ-039 Init test: mode=1, r=0, m=+1 -> all e=1; then m=-1 -> all e=2047.
REQ-040 Backpressure test: drop dout_tready 3 cycles during e[4] -> e[4] held stable, all 11 values delivered in order, valid-assertion latency matches REQ-025 (123 cycles at M=1, 35 at M=4).
REQ-041 Length-error test: tlast on beat 6 -> err_len=1, no output; a following good frame gives the correct result and clears err_len on its first beat; a 13-beat frame -> err_len=1 and the result uses beats 0..10.
REQ-042 Reset test: assert reset in mid-COMPUTE and again in mid-OUT -> all outputs 0 immediately, din_tready=1 one edge after release, and the next frame is correct.

Source files
------------

// File: rtl/ntru_axis_pkg.sv
// Shared constants, helper function and FSM state type for the NTRU
// stream polynomial multiplier.
package ntru_axis_pkg;

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FLUSH,
        ST_COMPUTE,
        ST_OUT
    } state_t;

    // Number of bits needed to hold 'value' (never less than 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) <= value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/ntru_au_lane.sv
// One arithmetic lane: accumulator plus, minus or pass of an h coefficient,
// selected by the ternary r coefficient. The 10 code behaves as zero.
module ntru_au_lane
    import ntru_axis_pkg::*;
#(
    parameter int Q_BITS = 11
) (
    input  logic [Q_BITS-1:0] acc_i,
    input  logic [Q_BITS-1:0] h_i,
    input  logic [1:0]        r_i,
    output logic [Q_BITS-1:0] res_o
);

    always_comb begin
        res_o = acc_i;
        if (r_i == TERN_POS) begin
            res_o = acc_i + h_i;
        end else if (r_i == TERN_NEG) begin
            res_o = acc_i - h_i;
        end
    end

endmodule

// File: rtl/ntru_axis_mult.sv
// AXI4-Stream NTRU convolution e = init + h*r mod (x^N - 1, 2^Q_BITS),
// computed in constant time with M parallel lanes.
//
// state      | meaning
// LOAD       | accept beats 0..N-1, store h, r and initial e
// FLUSH      | over-long frame: drop beats up to tlast
// COMPUTE    | N*ceil(N/M) accumulate cycles
// OUT        | stream e[0..N-1] out
module ntru_axis_mult
    import ntru_axis_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int N       = 11,
    parameter int Q_BITS  = 11,
    parameter int M       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] din_tdata,
    input  logic               din_tvalid,
    input  logic               din_tlast,
    output logic               din_tready,
    output logic [D_WIDTH-1:0] dout_tdata,
    output logic               dout_tvalid,
    output logic               dout_tlast,
    input  logic               dout_tready,
    output logic               busy,
    output logic               err_len
);

    localparam int AW = clog2(N - 1);
    localparam int SW = AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [SW-1:0] N_W = SW'(N);
    localparam logic [SW-1:0] M_W = SW'(M);

    if (Q_BITS + 4 > D_WIDTH - 1) begin : g_width_check
        $error("ntru_axis_mult: D_WIDTH too narrow for h/r/m/mode packing");
    end
    if (M < 1 || M > N) begin : g_lane_check
        $error("ntru_axis_mult: M must be in 1..N");
    end
    if (D_WIDTH - 2 >= Q_BITS + 4) begin : g_spare_bits
        logic unused_spare;
        assign unused_spare = ^din_tdata[D_WIDTH-2:Q_BITS+4];
    end

    state_t              state_q;
    logic [AW-1:0]       cnt_q, j_q, ib_q, oidx_q;
    logic                mode_q, prime_q;
    logic                din_tready_q, dout_tvalid_q, dout_tlast_q, busy_q, err_len_q;
    logic [Q_BITS-1:0]   dout_e_q;

    logic [Q_BITS-1:0]   h_q [N];
    logic [1:0]          r_q [N];
    logic [Q_BITS-1:0]   e_q [N];

    logic                accept;
    logic                mode_in;
    logic [1:0]          m_in;
    logic [Q_BITS-1:0]   init_in;
    logic [AW-1:0]       oidx_next;
    logic [1:0]          r_cur;

    logic [M-1:0]        lane_en;
    logic [AW-1:0]       lane_tgt [M];
    logic [Q_BITS-1:0]   lane_res [M];

    assign accept    = din_tvalid & din_tready_q;
    assign m_in      = din_tdata[Q_BITS+3:Q_BITS+2];
    assign mode_in   = (cnt_q == '0) ? din_tdata[D_WIDTH-1] : mode_q;
    assign oidx_next = oidx_q + 1'b1;
    assign r_cur     = r_q[j_q];

    always_comb begin
        init_in = '0;
        if (mode_in) begin
            if (m_in == TERN_POS) begin
                init_in = Q_BITS'(1);
            end else if (m_in == TERN_NEG) begin
                init_in = '1;
            end
        end
    end

    // Lane l handles h[ib+l] for the current r[j]; distinct i give distinct targets.
    for (genvar l = 0; l < M; l++) begin : g_lane
        logic [SW-1:0] idx_w, sum_w;
        logic [AW-1:0] h_idx;
        assign idx_w       = {1'b0, ib_q} + SW'(l);
        assign lane_en[l]  = idx_w < N_W;
        assign h_idx       = lane_en[l] ? idx_w[AW-1:0] : '0;
        assign sum_w       = idx_w + {1'b0, j_q};
        assign lane_tgt[l] = (sum_w >= N_W) ? AW'(sum_w - N_W) : sum_w[AW-1:0];

        ntru_au_lane #(.Q_BITS(Q_BITS)) u_lane (
            .acc_i (e_q[lane_tgt[l]]),
            .h_i   (h_q[h_idx]),
            .r_i   (r_cur),
            .res_o (lane_res[l])
        );
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && accept) begin
            h_q[cnt_q] <= din_tdata[Q_BITS-1:0];
            r_q[cnt_q] <= din_tdata[Q_BITS+1:Q_BITS];
            e_q[cnt_q] <= init_in;
        end
        if (state_q == ST_COMPUTE) begin
            for (int l = 0; l < M; l++) begin
                if (lane_en[l]) e_q[lane_tgt[l]] <= lane_res[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            cnt_q         <= '0;
            j_q           <= '0;
            ib_q          <= '0;
            oidx_q        <= '0;
            mode_q        <= 1'b0;
            prime_q       <= 1'b0;
            din_tready_q  <= 1'b0;
            dout_tvalid_q <= 1'b0;
            dout_tlast_q  <= 1'b0;
            dout_e_q      <= '0;
            busy_q        <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    din_tready_q <= 1'b1;
                    if (accept) begin
                        if (cnt_q == '0) begin
                            mode_q    <= din_tdata[D_WIDTH-1];
                            err_len_q <= 1'b0;
                        end
                        if (cnt_q == LAST_IDX) begin
                            cnt_q <= '0;
                            if (din_tlast) begin
                                state_q      <= ST_COMPUTE;
                                din_tready_q <= 1'b0;
                                busy_q       <= 1'b1;
                                j_q          <= '0;
                                ib_q         <= '0;
                            end else begin
                                state_q   <= ST_FLUSH;
                                err_len_q <= 1'b1;
                            end
                        end else if (din_tlast) begin
                            cnt_q     <= '0;
                            err_len_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (accept && din_tlast) begin
                        state_q      <= ST_COMPUTE;
                        din_tready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        j_q          <= '0;
                        ib_q         <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if ({1'b0, ib_q} + M_W >= N_W) begin
                        ib_q <= '0;
                        if (j_q == LAST_IDX) begin
                            state_q <= ST_OUT;
                            oidx_q  <= '0;
                            prime_q <= 1'b0;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        ib_q <= ib_q + AW'(M);
                    end
                end
                ST_OUT: begin
                    // One idle slot before the first beat fixes latency at N*ceil(N/M)+2.
                    if (!dout_tvalid_q) begin
                        if (prime_q) begin
                            dout_tvalid_q <= 1'b1;
                            dout_e_q      <= e_q[oidx_q];
                            dout_tlast_q  <= (oidx_q == LAST_IDX);
                        end else begin
                            prime_q <= 1'b1;
                        end
                    end else if (dout_tready) begin
                        if (dout_tlast_q) begin
                            dout_tvalid_q <= 1'b0;
                            dout_tlast_q  <= 1'b0;
                            busy_q        <= 1'b0;
                            din_tready_q  <= 1'b1;
                            state_q       <= ST_LOAD;
                        end else begin
                            oidx_q       <= oidx_next;
                            dout_e_q     <= e_q[oidx_next];
                            dout_tlast_q <= (oidx_next == LAST_IDX);
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign din_tready  = din_tready_q;
    assign dout_tdata  = {{(D_WIDTH - Q_BITS){1'b0}}, dout_e_q};
    assign dout_tvalid = dout_tvalid_q;
    assign dout_tlast  = dout_tlast_q;
    assign busy        = busy_q;
    assign err_len     = err_len_q;

endmodule

// File: tb/tb_ntru_axis_mult.sv
// Drives identical frames into an M=1 and an M=4 instance and checks both
// against a convolution reference model and the stream handshake rules.
module tb_ntru_axis_mult;

    localparam int DW = 32;
    localparam int NN = 11;
    localparam int QB = 11;
    localparam int M0 = 1;
    localparam int M1 = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din_tdata;
    logic          din_tvalid, din_tlast;
    logic          din_tready  [2];
    logic [DW-1:0] dout_tdata  [2];
    logic          dout_tvalid [2];
    logic          dout_tlast  [2];
    logic          dtr         [2];
    logic          busy        [2];
    logic          err_len     [2];

    int cyc = 0;
    int last_hs = 0;
    int checks = 0;
    int errors = 0;

    logic [QB-1:0] h_v [NN];
    logic [1:0]    r_v [NN];
    logic [1:0]    m_v [NN];
    logic          mode_v;
    logic [QB-1:0] exp_e [NN];
    logic          err_first [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntru_axis_mult #(.D_WIDTH(DW), .N(NN), .Q_BITS(QB), .M(M0)) u_dut0 (
        .clk(clk), .reset(reset),
        .din_tdata(din_tdata), .din_tvalid(din_tvalid), .din_tlast(din_tlast),
        .din_tready(din_tready[0]),
        .dout_tdata(dout_tdata[0]), .dout_tvalid(dout_tvalid[0]), .dout_tlast(dout_tlast[0]),
        .dout_tready(dtr[0]), .busy(busy[0]), .err_len(err_len[0])
    );

    ntru_axis_mult #(.D_WIDTH(DW), .N(NN), .Q_BITS(QB), .M(M1)) u_dut1 (
        .clk(clk), .reset(reset),
        .din_tdata(din_tdata), .din_tvalid(din_tvalid), .din_tlast(din_tlast),
        .din_tready(din_tready[1]),
        .dout_tdata(dout_tdata[1]), .dout_tvalid(dout_tvalid[1]), .dout_tlast(dout_tlast[1]),
        .dout_tready(dtr[1]), .busy(busy[1]), .err_len(err_len[1])
    );

    function automatic int tval(input logic [1:0] t);
        if (t == 2'b01) return 1;
        if (t == 2'b11) return -1;
        return 0;
    endfunction

    // Cyclic convolution straight from the definition.
    task automatic build_model();
        int acc;
        for (int k = 0; k < NN; k++) begin
            acc = mode_v ? tval(m_v[k]) : 0;
            for (int i = 0; i < NN; i++)
                acc += int'(h_v[i]) * tval(r_v[(k - i + NN) % NN]);
            exp_e[k] = acc[QB-1:0];
        end
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < NN; i++) begin
            h_v[i] = QB'($urandom);
            r_v[i] = 2'($urandom_range(0, 3));
            m_v[i] = 2'($urandom_range(0, 3));
        end
        mode_v = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input int nbeats);
        logic [DW-1:0] w;
        int t;
        for (int b = 0; b < nbeats; b++) begin
            w = $urandom;
            if (b < NN) begin
                w[QB-1:0]    = h_v[b];
                w[QB+1:QB]   = r_v[b];
                w[QB+3:QB+2] = m_v[b];
            end
            if (b == 0) w[DW-1] = mode_v;
            t = 0;
            while (!(din_tready[0] === 1'b1 && din_tready[1] === 1'b1) && t < 300) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 300) begin
                checks++; errors++;
                $display("FAIL din_tready_timeout beat %0d: ready %b/%b, required 1", b, din_tready[0], din_tready[1]);
            end
            din_tdata  = w;
            din_tvalid = 1'b1;
            din_tlast  = (b == nbeats - 1);
            @(posedge clk); #1;
            if (b == 0) begin
                err_first[0] = err_len[0];
                err_first[1] = err_len[1];
            end
        end
        last_hs    = cyc;
        din_tvalid = 1'b0;
        din_tlast  = 1'b0;
    endtask

    task automatic collect(input int stall_idx);
        int idx [2];
        int wc [2];
        bit seen [2];
        bit fin [2];
        logic [DW-1:0] hold [2];
        int lat_exp [2];
        lat_exp[0] = NN * ((NN + M0 - 1) / M0) + 2;
        lat_exp[1] = NN * ((NN + M1 - 1) / M1) + 2;
        for (int k = 0; k < 2; k++) begin
            idx[k] = 0; wc[k] = 0; seen[k] = 0; fin[k] = 0; hold[k] = '0; dtr[k] = 1'b1;
        end
        for (int t = 0; t < 400 && !(fin[0] && fin[1]); t++) begin
            for (int k = 0; k < 2; k++) begin
                if (!fin[k]) begin
                    if (idx[k] == NN) begin
                        checks++;
                        if (dout_tvalid[k] !== 1'b0 || din_tready[k] !== 1'b1) begin
                            errors++;
                            $display("FAIL post_frame dut%0d: valid %b ready %b, required valid 0 ready 1",
                                     k, dout_tvalid[k], din_tready[k]);
                        end
                        fin[k] = 1;
                    end else begin
                        if (idx[k] == stall_idx && wc[k] > 0) begin
                            checks++;
                            if (dout_tvalid[k] !== 1'b1 || dout_tdata[k] !== hold[k]) begin
                                errors++;
                                $display("FAIL stall_hold dut%0d: valid %b data %0d, required valid 1 data %0d",
                                         k, dout_tvalid[k], dout_tdata[k], hold[k]);
                            end
                        end
                        if (dout_tvalid[k] === 1'b1) begin
                            if (!seen[k]) begin
                                seen[k] = 1;
                                checks++;
                                if (cyc - last_hs != lat_exp[k]) begin
                                    errors++;
                                    $display("FAIL latency dut%0d: got %0d cycles, required %0d",
                                             k, cyc - last_hs, lat_exp[k]);
                                end
                            end
                            if (idx[k] == stall_idx && wc[k] < 3) begin
                                if (wc[k] == 0) hold[k] = dout_tdata[k];
                                dtr[k] = 1'b0;
                                wc[k]++;
                            end else begin
                                dtr[k] = 1'b1;
                                checks++;
                                if (dout_tdata[k] !== {{(DW-QB){1'b0}}, exp_e[idx[k]]} ||
                                    dout_tlast[k] !== (idx[k] == NN - 1)) begin
                                    errors++;
                                    $display("FAIL result dut%0d e[%0d]: got %0d last %b, required %0d last %b",
                                             k, idx[k], dout_tdata[k], dout_tlast[k], exp_e[idx[k]], (idx[k] == NN - 1));
                                end
                                idx[k]++;
                            end
                        end
                    end
                end
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin
            if (!fin[k]) begin
                checks++; errors++;
                $display("FAIL collect_timeout dut%0d: got %0d beats, required %0d", k, idx[k], NN);
            end
            dtr[k] = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (din_tready[k] !== 1'b0 || dout_tvalid[k] !== 1'b0 || dout_tlast[k] !== 1'b0 ||
                dout_tdata[k] !== '0 || busy[k] !== 1'b0 || err_len[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d: rdy %b vld %b lst %b data %0d busy %b err %b, required all 0",
                         tag, k, din_tready[k], dout_tvalid[k], dout_tlast[k], dout_tdata[k], busy[k], err_len[k]);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("reset_release");
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (din_tready[k] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset dut%0d: got %b, required 1", k, din_tready[k]);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_rotation();
        for (int i = 0; i < NN; i++) begin
            h_v[i] = QB'(i + 1);
            r_v[i] = 2'b00;
            m_v[i] = 2'($urandom_range(0, 3));
        end
        r_v[1] = 2'b01;
        mode_v = 1'b0;
        for (int k = 0; k < NN; k++) exp_e[k] = (k == 0) ? QB'(11) : QB'(k);
        send_frame(NN);
        collect(-1);
    endtask

    task automatic test_negation();
        for (int i = 0; i < NN; i++) begin
            h_v[i] = '0; r_v[i] = 2'b00; m_v[i] = 2'b00; exp_e[i] = '0;
        end
        h_v[0] = QB'(5);
        r_v[0] = 2'b11;
        mode_v = 1'b0;
        exp_e[0] = QB'(2043);
        send_frame(NN);
        collect(-1);
    endtask

    task automatic test_init();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NN; i++) begin
                h_v[i] = QB'($urandom);
                r_v[i] = 2'b00;
                m_v[i] = (pass == 0) ? 2'b01 : 2'b11;
                exp_e[i] = (pass == 0) ? QB'(1) : QB'(2047);
            end
            mode_v = 1'b1;
            send_frame(NN);
            collect(-1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            randomize_frame();
            build_model();
            send_frame(NN);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (err_len[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL err_len_good dut%0d: got %b, required 0", k, err_len[k]);
                end
            end
            collect(-1);
        end
    endtask

    task automatic test_backpressure();
        randomize_frame();
        build_model();
        send_frame(NN);
        collect(4);
    endtask

    task automatic test_len_err();
        randomize_frame();
        send_frame(7);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (err_len[k] !== 1'b1) begin
                errors++;
                $display("FAIL err_len_short dut%0d: got %b, required 1", k, err_len[k]);
            end
        end
        repeat (5) begin @(posedge clk); #1; end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout_tvalid[k] !== 1'b0 || busy[k] !== 1'b0 || din_tready[k] !== 1'b1) begin
                errors++;
                $display("FAIL short_no_output dut%0d: vld %b busy %b rdy %b, required 0 0 1",
                         k, dout_tvalid[k], busy[k], din_tready[k]);
            end
        end
        randomize_frame();
        build_model();
        send_frame(NN);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (err_first[k] !== 1'b0) begin
                errors++;
                $display("FAIL err_len_clear dut%0d: got %b, required 0", k, err_first[k]);
            end
        end
        collect(-1);
        randomize_frame();
        build_model();
        send_frame(13);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (err_len[k] !== 1'b1) begin
                errors++;
                $display("FAIL err_len_long dut%0d: got %b, required 1", k, err_len[k]);
            end
        end
        collect(-1);
    endtask

    task automatic test_reset_mid();
        int t;
        randomize_frame();
        build_model();
        send_frame(NN);
        repeat (20) begin @(posedge clk); #1; end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy[k] !== 1'b1) begin
                errors++;
                $display("FAIL busy_compute dut%0d: got %b, required 1", k, busy[k]);
            end
        end
        apply_reset();
        randomize_frame();
        build_model();
        send_frame(NN);
        collect(-1);

        randomize_frame();
        build_model();
        dtr[0] = 1'b0;
        dtr[1] = 1'b0;
        send_frame(NN);
        t = 0;
        while (!(dout_tvalid[0] === 1'b1 && dout_tvalid[1] === 1'b1) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL out_wait_timeout: valid %b/%b, required 1/1", dout_tvalid[0], dout_tvalid[1]);
        end
        apply_reset();
        dtr[0] = 1'b1;
        dtr[1] = 1'b1;
        randomize_frame();
        build_model();
        send_frame(NN);
        collect(-1);
    endtask

    initial begin
        reset      = 1'b0;
        din_tdata  = '0;
        din_tvalid = 1'b0;
        din_tlast  = 1'b0;
        dtr[0]     = 1'b1;
        dtr[1]     = 1'b1;
        #3;
        test_reset();
        test_rotation();
        test_negation();
        test_init();
        test_random();
        test_backpressure();
        test_len_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
